// File: rtl/baby_store_pkg.sv
// baby_store_pkg: shared constants and the controller state type for the
// baby store responder.
//   WORDS  - number of store words (32)
//   ADDR_W - word-address width
//   DATA_W - word width
//   state_e - controller states; ST_DUMP exists only when BABY_STORE_DUMP_EN
//             is defined.
package baby_store_pkg;

  localparam int WORDS  = 32;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_RUN  = 3'd2,
    ST_HALT = 3'd3
`ifdef BABY_STORE_DUMP_EN
    ,
    ST_DUMP = 3'd4
`endif
  } state_e;

endpackage

// File: rtl/baby_store_responder_if.sv
// baby_store_responder_if: bundles the core memory bus, the program-loader
// stream, the control/status outputs and (with BABY_STORE_DUMP_EN) the
// dump stream.
//   master - the core/loader side (drives the *_i signals)
//   slave  - the responder side (drives the *_o signals)
interface baby_store_responder_if
  import baby_store_pkg::*;
#(
  parameter int ADDR_W = baby_store_pkg::ADDR_W,
  parameter int DATA_W = baby_store_pkg::DATA_W
);

  // core memory bus
  logic [ADDR_W-1:0] ram_addr_i;
  logic              ram_rw_en_i;
  logic [DATA_W-1:0] ram_data_i;
  logic [DATA_W-1:0] ram_data_o;
  logic              stop_lamp_i;

  // program loader
  logic              load_start_i;
  logic              load_valid_i;
  logic [DATA_W-1:0] load_data_i;
  logic              load_ready_o;

  // status
  logic              loading_o;
  logic              core_reset_o;

`ifdef BABY_STORE_DUMP_EN
  // dump stream
  logic              dump_valid_o;
  logic [ADDR_W-1:0] dump_addr_o;
  logic [DATA_W-1:0] dump_data_o;
  logic              dump_ready_i;
`endif

  modport master (
    output ram_addr_i, ram_rw_en_i, ram_data_i, stop_lamp_i,
    output load_start_i, load_valid_i, load_data_i,
    input  ram_data_o, load_ready_o, loading_o, core_reset_o
`ifdef BABY_STORE_DUMP_EN
    ,
    input  dump_valid_o, dump_addr_o, dump_data_o,
    output dump_ready_i
`endif
  );

  modport slave (
    input  ram_addr_i, ram_rw_en_i, ram_data_i, stop_lamp_i,
    input  load_start_i, load_valid_i, load_data_i,
    output ram_data_o, load_ready_o, loading_o, core_reset_o
`ifdef BABY_STORE_DUMP_EN
    ,
    output dump_valid_o, dump_addr_o, dump_data_o,
    input  dump_ready_i
`endif
  );

endinterface

// File: rtl/baby_store_ram.sv
// baby_store_ram: WORDS x DATA_W storage array.
//   clock, reset_i      - clock and synchronous active-high reset (clears
//                         only the read register, never the array)
//   we, waddr, wdata    - single write port
//   raddr, rdata        - registered read port, one-cycle latency,
//                         read-before-write on address collision
//   dump_raddr/rdata    - combinational second read port (BABY_STORE_DUMP_EN)
module baby_store_ram
  import baby_store_pkg::*;
#(
  parameter int ADDR_W = baby_store_pkg::ADDR_W,
  parameter int DATA_W = baby_store_pkg::DATA_W
) (
  input  logic              clock,
  input  logic              reset_i,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
`ifdef BABY_STORE_DUMP_EN
  ,
  input  logic [ADDR_W-1:0] dump_raddr,
  output logic [DATA_W-1:0] dump_rdata
`endif
);

  logic [DATA_W-1:0] mem_r [WORDS];
  logic [DATA_W-1:0] rdata_r;

  // array write port; contents deliberately survive reset
  always_ff @(posedge clock) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // registered read; sampling the old word gives read-before-write
  always_ff @(posedge clock) begin
    if (reset_i) begin
      rdata_r <= {DATA_W{1'b0}};
    end else begin
      rdata_r <= mem_r[raddr];
    end
  end

  assign rdata = rdata_r;

`ifdef BABY_STORE_DUMP_EN
  // no writes happen while dumping, so this word is stable across stalls
  assign dump_rdata = mem_r[dump_raddr];
`endif

endmodule

// File: rtl/baby_store_responder.sv
// baby_store_responder: program store for a small core. Loads a 32-word
// program from a valid/ready stream while holding the core in reset, then
// serves core reads/writes until the core lights its stop lamp.
//   clock   - single rising-edge clock
//   reset_i - synchronous active-high reset (memory contents are kept)
//   bus     - baby_store_responder_if.slave: core bus, loader stream,
//             loading_o/core_reset_o status, and the dump stream when the
//             BABY_STORE_DUMP_EN macro is defined (stop lamp then streams all
//             32 words out before halting).
module baby_store_responder
  import baby_store_pkg::*;
#(
  parameter int ADDR_W = baby_store_pkg::ADDR_W,
  parameter int DATA_W = baby_store_pkg::DATA_W
) (
  input  logic                  clock,
  input  logic                  reset_i,
  baby_store_responder_if.slave bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ONE_ADDR  = {{(ADDR_W-1){1'b0}}, 1'b1};

  // status bits {core_reset, load_ready, loading} presented in a given state
  function automatic logic [2:0] ctrl_for(input state_e s);
    logic [2:0] c;
    case (s)
      ST_IDLE: c = 3'b100;
      ST_LOAD: c = 3'b111;
      ST_RUN:  c = 3'b000;
      ST_HALT: c = 3'b000;
`ifdef BABY_STORE_DUMP_EN
      ST_DUMP: c = 3'b000;
`endif
      default: c = 3'b100;
    endcase
    return c;
  endfunction

  state_e            state_r;
  logic [ADDR_W-1:0] cnt_r;
  logic [2:0]        ctrl_r;
  logic              load_accept_s;
  logic              core_write_s;
  logic              we_s;
  logic [ADDR_W-1:0] waddr_s;
  logic [DATA_W-1:0] wdata_s;
  logic [DATA_W-1:0] rdata_s;

`ifdef BABY_STORE_DUMP_EN
  logic              dump_valid_r;
  logic [ADDR_W-1:0] dump_addr_r;
  logic [DATA_W-1:0] dump_rdata_s;
`endif

  // write-port arbitration: loader owns it in LOAD, the core only in RUN
  always_comb begin
    load_accept_s = (state_r == ST_LOAD) && bus.load_valid_i && ctrl_r[1];
    core_write_s  = (state_r == ST_RUN) && bus.ram_rw_en_i;
    we_s          = load_accept_s || core_write_s;
    if (load_accept_s) begin
      waddr_s = cnt_r;
      wdata_s = bus.load_data_i;
    end else begin
      waddr_s = bus.ram_addr_i;
      wdata_s = bus.ram_data_i;
    end
  end

  // controller FSM with registered status outputs
  always_ff @(posedge clock) begin
    if (reset_i) begin
      state_r      <= ST_IDLE;
      cnt_r        <= ZERO_ADDR;
      ctrl_r       <= ctrl_for(ST_IDLE);
`ifdef BABY_STORE_DUMP_EN
      dump_valid_r <= 1'b0;
      dump_addr_r  <= ZERO_ADDR;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.load_start_i) begin
            state_r <= ST_LOAD;
            cnt_r   <= ZERO_ADDR;
            ctrl_r  <= ctrl_for(ST_LOAD);
          end
        end
        ST_LOAD: begin
          // a fresh start request rewinds the counter but keeps written words
          if (bus.load_start_i) begin
            cnt_r <= ZERO_ADDR;
          end else if (load_accept_s) begin
            cnt_r <= cnt_r + ONE_ADDR;
            if (cnt_r == LAST_ADDR) begin
              state_r <= ST_RUN;
              ctrl_r  <= ctrl_for(ST_RUN);
            end
          end
        end
        ST_RUN: begin
          // stop lamp has priority; load_start_i is not looked at here
          if (bus.stop_lamp_i) begin
`ifdef BABY_STORE_DUMP_EN
            state_r      <= ST_DUMP;
            ctrl_r       <= ctrl_for(ST_DUMP);
            dump_valid_r <= 1'b1;
            dump_addr_r  <= ZERO_ADDR;
`else
            state_r <= ST_HALT;
            ctrl_r  <= ctrl_for(ST_HALT);
`endif
          end
        end
        ST_HALT: begin
          if (bus.load_start_i) begin
            state_r <= ST_LOAD;
            cnt_r   <= ZERO_ADDR;
            ctrl_r  <= ctrl_for(ST_LOAD);
          end
        end
`ifdef BABY_STORE_DUMP_EN
        ST_DUMP: begin
          if (dump_valid_r && bus.dump_ready_i) begin
            if (dump_addr_r == LAST_ADDR) begin
              state_r      <= ST_HALT;
              ctrl_r       <= ctrl_for(ST_HALT);
              dump_valid_r <= 1'b0;
            end else begin
              dump_addr_r <= dump_addr_r + ONE_ADDR;
            end
          end
        end
`endif
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= ZERO_ADDR;
          ctrl_r  <= ctrl_for(ST_IDLE);
        end
      endcase
    end
  end

  baby_store_ram #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_ram (
    .clock      (clock),
    .reset_i    (reset_i),
    .we         (we_s),
    .waddr      (waddr_s),
    .wdata      (wdata_s),
    .raddr      (bus.ram_addr_i),
    .rdata      (rdata_s)
`ifdef BABY_STORE_DUMP_EN
    ,
    .dump_raddr (dump_addr_r),
    .dump_rdata (dump_rdata_s)
`endif
  );

  assign bus.ram_data_o   = rdata_s;
  assign bus.core_reset_o = ctrl_r[2];
  assign bus.load_ready_o = ctrl_r[1];
  assign bus.loading_o    = ctrl_r[0];

`ifdef BABY_STORE_DUMP_EN
  assign bus.dump_valid_o = dump_valid_r;
  assign bus.dump_addr_o  = dump_addr_r;
  assign bus.dump_data_o  = dump_rdata_s;
`endif

endmodule

// File: tb/tb_baby_store_responder.sv
// tb_baby_store_responder: directed, table-driven bench for
// baby_store_responder. Honours BABY_STORE_DUMP_EN for the dump stream.
module tb_baby_store_responder;
  import baby_store_pkg::*;

  localparam int AW = 5;
  localparam int DW = 32;

  logic clock = 1'b0;
  logic reset_i = 1'b1;
  always #5 clock = ~clock;

  baby_store_responder_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

  baby_store_responder #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clock   (clock),
    .reset_i (reset_i),
    .bus     (bus)
  );

  int checks = 0;
  int fails  = 0;
  logic [DW-1:0] model [32];
  int model_cnt = 0;

  typedef struct {
    logic [AW-1:0] addr;
    logic          rw;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rdata;
  } vec_t;
  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic read_check(input string name, input logic [AW-1:0] addr, input logic [DW-1:0] exp);
    bus.ram_addr_i  = addr;
    bus.ram_rw_en_i = 1'b0;
    step();
    check(name, bus.ram_data_o, exp);
  endtask

  task automatic start_load(input string name);
    bus.load_start_i = 1'b1;
    step();
    bus.load_start_i = 1'b0;
    model_cnt = 0;
    check({name, "_loading"}, bus.loading_o, 32'd1);
    check({name, "_ready"}, bus.load_ready_o, 32'd1);
    check({name, "_core_reset"}, bus.core_reset_o, 32'd1);
  endtask

  // stream n words base+i; toggle inserts an idle cycle between words
  task automatic load_words(input int n, input bit toggle, input logic [DW-1:0] base,
                            input bit expect_run);
    int accepted;
    int cyc;
    int not_loading;
    accepted = 0;
    cyc = 0;
    not_loading = 0;
    while (accepted < n && cyc < 400) begin
      bus.load_valid_i = toggle ? (cyc % 2 == 0) : 1'b1;
      bus.load_data_i  = base + accepted;
      if (bus.load_valid_i && bus.load_ready_o) begin
        if (bus.loading_o !== 1'b1) not_loading++;
        model[model_cnt] = base + accepted;
        model_cnt = (model_cnt + 1) % 32;
        accepted++;
      end
      cyc++;
      step();
    end
    bus.load_valid_i = 1'b0;
    check("load_accepts", accepted, n);
    check("loading_during_accepts", not_loading, 32'd0);
    if (expect_run) begin
      check("run_loading", bus.loading_o, 32'd0);
      check("run_core_reset", bus.core_reset_o, 32'd0);
      check("run_ready", bus.load_ready_o, 32'd0);
    end else begin
      check("still_loading", bus.loading_o, 32'd1);
    end
  endtask

  task automatic stop_to_halt(input bit stall, input bit with_start);
`ifdef BABY_STORE_DUMP_EN
    int idx;
    int k;
`endif
    bus.stop_lamp_i  = 1'b1;
    bus.load_start_i = with_start;
    step();
    bus.stop_lamp_i  = 1'b0;
    bus.load_start_i = 1'b0;
    check("stop_loading", bus.loading_o, 32'd0);
    check("stop_core_reset", bus.core_reset_o, 32'd0);
`ifdef BABY_STORE_DUMP_EN
    idx = 0;
    k = 0;
    while (idx < 32 && k < 400) begin
      bus.dump_ready_i = stall ? (k % 3 != 2) : 1'b1;
      check("dump_valid", bus.dump_valid_o, 32'd1);
      check("dump_addr", bus.dump_addr_o, idx);
      check("dump_data", bus.dump_data_o, model[idx]);
      if (bus.dump_ready_i) idx++;
      k++;
      step();
    end
    bus.dump_ready_i = 1'b0;
    check("dump_count", idx, 32'd32);
    check("dump_done_valid", bus.dump_valid_o, 32'd0);
`else
    if (stall) check("halt_ready", bus.load_ready_o, 32'd0);
`endif
  endtask

  initial begin
    vecs[0] = '{5'd5,  1'b0, 32'h0,        32'h5};
    vecs[1] = '{5'd5,  1'b1, 32'hDEADBEEF, 32'h5};
    vecs[2] = '{5'd5,  1'b0, 32'h0,        32'hDEADBEEF};
    vecs[3] = '{5'd7,  1'b1, 32'h12345678, 32'h7};
    vecs[4] = '{5'd7,  1'b0, 32'h0,        32'h12345678};
    vecs[5] = '{5'd31, 1'b0, 32'h0,        32'h1F};
    vecs[6] = '{5'd0,  1'b0, 32'h0,        32'h0};
    vecs[7] = '{5'd12, 1'b1, 32'h0000CAFE, 32'hC};
    vecs[8] = '{5'd12, 1'b0, 32'h0,        32'h0000CAFE};

    bus.ram_addr_i   = '0;
    bus.ram_rw_en_i  = 1'b0;
    bus.ram_data_i   = '0;
    bus.stop_lamp_i  = 1'b0;
    bus.load_start_i = 1'b0;
    bus.load_valid_i = 1'b0;
    bus.load_data_i  = '0;
`ifdef BABY_STORE_DUMP_EN
    bus.dump_ready_i = 1'b0;
`endif

    // reset state
    reset_i = 1'b1;
    step();
    step();
    check("rst_core_reset", bus.core_reset_o, 32'd1);
    check("rst_ready", bus.load_ready_o, 32'd0);
    check("rst_loading", bus.loading_o, 32'd0);
    check("rst_rdata", bus.ram_data_o, 32'd0);
`ifdef BABY_STORE_DUMP_EN
    check("rst_dump_valid", bus.dump_valid_o, 32'd0);
`endif
    reset_i = 1'b0;
    step();
    check("idle_core_reset", bus.core_reset_o, 32'd1);
    check("idle_ready", bus.load_ready_o, 32'd0);

    // plain load of 0..31
    start_load("load1");
    load_words(32, 1'b0, 32'h0, 1'b1);

    // RUN vectors
    for (int i = 0; i < 9; i++) begin
      bus.ram_addr_i  = vecs[i].addr;
      bus.ram_rw_en_i = vecs[i].rw;
      bus.ram_data_i  = vecs[i].wdata;
      step();
      check($sformatf("vec%0d_rdata", i), bus.ram_data_o, vecs[i].exp_rdata);
      if (vecs[i].rw) model[vecs[i].addr] = vecs[i].wdata;
    end
    bus.ram_rw_en_i = 1'b0;

    // load_start_i alone is ignored in RUN
    bus.load_start_i = 1'b1;
    step();
    bus.load_start_i = 1'b0;
    check("run_ignore_start", bus.loading_o, 32'd0);

    // stop lamp and load start together: stop lamp wins
    stop_to_halt(1'b1, 1'b1);
    check("halt_loading", bus.loading_o, 32'd0);
    check("halt_core_reset", bus.core_reset_o, 32'd0);

    // core write in HALT is ignored
    bus.ram_addr_i  = 5'd3;
    bus.ram_rw_en_i = 1'b1;
    bus.ram_data_i  = 32'hBAD0BAD0;
    step();
    bus.ram_rw_en_i = 1'b0;
    step();
    check("halt_write_ignored", bus.ram_data_o, 32'h3);

    // reload from HALT with load_valid_i toggling
    start_load("load2");
    load_words(32, 1'b1, 32'h100, 1'b1);
    read_check("load2_w0", 5'd0, 32'h100);
    read_check("load2_w31", 5'd31, 32'h11F);
    read_check("load2_w5", 5'd5, 32'h105);

    // partial load then reset
    stop_to_halt(1'b0, 1'b0);
    start_load("load3");
    load_words(10, 1'b0, 32'h200, 1'b0);
    reset_i = 1'b1;
    step();
    check("rst2_loading", bus.loading_o, 32'd0);
    check("rst2_core_reset", bus.core_reset_o, 32'd1);
    check("rst2_rdata", bus.ram_data_o, 32'd0);
    reset_i = 1'b0;
    step();
    check("rst2_idle_ready", bus.load_ready_o, 32'd0);

    // new load writes word 0 only; other words kept
    start_load("load4");
    load_words(1, 1'b0, 32'h300, 1'b0);
    read_check("keep_w1", 5'd1, 32'h201);
    read_check("keep_w9", 5'd9, 32'h209);
    read_check("keep_w10", 5'd10, 32'h10A);
    read_check("new_w0", 5'd0, 32'h300);

    // restart during LOAD rewinds to word 0
    start_load("restart");
    load_words(1, 1'b0, 32'h400, 1'b0);
    read_check("restart_w0", 5'd0, 32'h400);
    read_check("restart_w1", 5'd1, 32'h201);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
